// File: rtl/ah_snoop_hazard_gate.sv
// Snoop hazard gate: holds one request, snoops its key against a FIFO and forwards it
// only when no older in-flight entry shares the key. Optional AH_SNOOP_HAZARD_CNT_EN adds hazard_count.
// Ports: clk, rstn | in_data/in_valid/in_ready | out_data/out_valid/out_ready
//        sdata/svalid/smatch | hazard_stall, hazard_timeout [, hazard_count]
`timescale 1ns/1ps
module ah_snoop_hazard_gate #(
  parameter int DATA_W      = 110,
  parameter int SNOOP_W     = 32,
  parameter int SNOOP_LSB   = 0,
  parameter int RETRY_GAP   = 4,
  parameter int MAX_RETRIES = 15
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SNOOP_W-1:0] sdata,
  output logic               svalid,
  input  logic               smatch,
  output logic               hazard_stall,
  output logic               hazard_timeout
`ifdef AH_SNOOP_HAZARD_CNT_EN
  ,
  output logic [15:0]        hazard_count
`endif
);

  localparam int GW = $clog2(RETRY_GAP + 1);
  localparam logic [GW-1:0] GAP_INIT = GW'(RETRY_GAP - 1);
  localparam logic [7:0] MAX8 = 8'(MAX_RETRIES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SNOOP,
    S_WAIT,
    S_SEND
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [7:0]        retry_cnt_q, retry_cnt_d;
  logic [7:0]        retry_inc;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic              timeout_q, timeout_d;
  logic              in_fire;
  logic              out_fire;
  logic              hit;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      retry_cnt_q <= '0;
      gap_cnt_q   <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      retry_cnt_q <= retry_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // Outputs decode from state only; out_ready reaches in_ready in SEND.
  always_comb begin
    in_ready     = 1'b0;
    svalid       = 1'b0;
    out_valid    = 1'b0;
    hazard_stall = 1'b0;
    unique case (state_q)
      S_IDLE:  in_ready = 1'b1;
      S_SNOOP: svalid = 1'b1;
      S_WAIT:  hazard_stall = 1'b1;
      S_SEND: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  assign in_fire        = in_valid & in_ready;
  assign out_fire       = out_valid & out_ready;
  assign hit            = (state_q == S_SNOOP) & smatch;
  assign retry_inc      = (retry_cnt_q == 8'hFF) ? 8'hFF : retry_cnt_q + 8'd1;
  assign out_data       = hold_q;
  assign sdata          = hold_q[SNOOP_LSB +: SNOOP_W];
  assign hazard_timeout = timeout_q;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    retry_cnt_d = retry_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    // Fires only on the transition into MAX, so saturation never repeats it.
    timeout_d   = hit && (retry_inc == MAX8) && (retry_cnt_q != MAX8);
    unique case (state_q)
      S_IDLE: begin
        if (in_fire) begin
          hold_d      = in_data;
          retry_cnt_d = '0;
          state_d     = S_SNOOP;
        end
      end
      S_SNOOP: begin
        if (smatch) begin
          retry_cnt_d = retry_inc;
          gap_cnt_d   = GAP_INIT;
          state_d     = S_WAIT;
        end else begin
          state_d = S_SEND;
        end
      end
      S_WAIT: begin
        if (gap_cnt_q == '0) begin
          state_d = S_SNOOP;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      S_SEND: begin
        if (out_fire && in_fire) begin
          hold_d      = in_data;
          retry_cnt_d = '0;
          state_d     = S_SNOOP;
        end else if (out_fire) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef AH_SNOOP_HAZARD_CNT_EN
  logic [15:0] hcnt_q, hcnt_d;

  always_comb begin
    hcnt_d = hcnt_q;
    if (hit && hcnt_q != 16'hFFFF) begin
      hcnt_d = hcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
    end
  end

  assign hazard_count = hcnt_q;
`endif

endmodule

// File: tb/tb_ah_snoop_hazard_gate.sv
// Bench for ah_snoop_hazard_gate: scenario tasks plus a scoreboard
// of accepted payloads checked against every output transfer.
`timescale 1ns/1ps
module tb_ah_snoop_hazard_gate;

  localparam int DW  = 110;
  localparam int SW  = 32;
  localparam int LSB = 0;
  localparam int GAP = 4;
  localparam int MR  = 3;

  logic          clk = 1'b0;
  logic          rstn;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] sdata;
  logic          svalid;
  logic          smatch;
  logic          hazard_stall;
  logic          hazard_timeout;
`ifdef AH_SNOOP_HAZARD_CNT_EN
  logic [15:0]   hazard_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_exp;

  always #5 clk = ~clk;

  ah_snoop_hazard_gate #(
    .DATA_W(DW), .SNOOP_W(SW), .SNOOP_LSB(LSB),
    .RETRY_GAP(GAP), .MAX_RETRIES(MR)
  ) dut (
    .clk(clk), .rstn(rstn),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sdata(sdata), .svalid(svalid), .smatch(smatch),
    .hazard_stall(hazard_stall), .hazard_timeout(hazard_timeout)
`ifdef AH_SNOOP_HAZARD_CNT_EN
    , .hazard_count(hazard_count)
`endif
  );

  // Scoreboard: every output transfer must match the oldest accepted payload.
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_xfer: got transfer %h, required none", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_data !== mon_exp) begin
          n_fail++;
          $display("FAIL sb_data: got %h, required %h", out_data, mon_exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] mk(input logic [SW-1:0] key);
    logic [DW-1:0] d;
    d = DW'({$urandom(), $urandom(), $urandom(), $urandom()});
    d[LSB +: SW] = key;
    return d;
  endfunction

  // Present one request in IDLE; returns in cycle N+1.
  task automatic accept(input logic [DW-1:0] d);
    in_data  = d;
    in_valid = 1'b1;
    exp_q.push_back(d);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b1; smatch = 1'b0;
    tick(); tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    n_checks++; if (svalid !== 1'b0) begin n_fail++; $display("FAIL rst_svalid: got %b want 0", svalid); end
    n_checks++; if (sdata !== '0) begin n_fail++; $display("FAIL rst_sdata: got %h want 0", sdata); end
    n_checks++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", hazard_stall); end
    n_checks++; if (hazard_timeout !== 1'b0) begin n_fail++; $display("FAIL rst_timeout: got %b want 0", hazard_timeout); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_no_hazard;
    logic [DW-1:0] d;
    d = mk(32'h1234);
    smatch = 1'b0; out_ready = 1'b1;
    accept(d);
    n_checks++; if (svalid !== 1'b1) begin n_fail++; $display("FAIL nh_svalid: got %b want 1", svalid); end
    n_checks++; if (sdata !== 32'h1234) begin n_fail++; $display("FAIL nh_sdata: got %h want 1234", sdata); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL nh_in_ready: got %b want 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL nh_early_out: got %b want 0", out_valid); end
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL nh_out_valid: got %b want 1", out_valid); end
    n_checks++; if (svalid !== 1'b0) begin n_fail++; $display("FAIL nh_svalid2: got %b want 0", svalid); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL nh_idle_ov: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL nh_idle_ir: got %b want 1", in_ready); end
  endtask

  task automatic test_single_hazard;
    accept(mk(32'h0000_5A5A));
    n_checks++; if (svalid !== 1'b1) begin n_fail++; $display("FAIL sh_svalid1: got %b want 1", svalid); end
    smatch = 1'b1;
    for (int i = 0; i < GAP; i++) begin
      tick();
      smatch = 1'b0;
      n_checks++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL sh_stall[%0d]: got %b want 1", i, hazard_stall); end
      n_checks++; if (svalid !== 1'b0) begin n_fail++; $display("FAIL sh_svalid_wait[%0d]: got %b want 0", i, svalid); end
    end
    tick();
    n_checks++; if (svalid !== 1'b1) begin n_fail++; $display("FAIL sh_svalid2: got %b want 1", svalid); end
    n_checks++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL sh_stall_end: got %b want 0", hazard_stall); end
    n_checks++; if (sdata !== 32'h0000_5A5A) begin n_fail++; $display("FAIL sh_sdata: got %h want 5a5a", sdata); end
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sh_out_valid: got %b want 1", out_valid); end
    tick();
  endtask

  task automatic test_timeout;
    bit done;
    smatch = 1'b1;
    accept(mk(32'hCAFE_0001));
    for (int k = 1; k <= 25; k++) begin
      if (k > 1) tick();
      n_checks++; if (svalid !== ((k % 5) == 1)) begin n_fail++; $display("FAIL to_svalid[k=%0d]: got %b want %b", k, svalid, ((k % 5) == 1)); end
      n_checks++; if (hazard_timeout !== (k == 12)) begin n_fail++; $display("FAIL to_pulse[k=%0d]: got %b want %b", k, hazard_timeout, (k == 12)); end
    end
    smatch = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      tick();
      done = out_valid;
    end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL to_release: got out_valid %b want 1", out_valid); end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] a, b;
    a = mk(32'hAAAA_0001);
    b = mk(32'hBBBB_0002);
    smatch = 1'b0; out_ready = 1'b0;
    accept(a);
    in_data = b; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_ov[%0d]: got %b want 1", i, out_valid); end
      n_checks++; if (out_data !== a) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", i, out_data, a); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ir[%0d]: got %b want 0", i, in_ready); end
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bb_ir: got %b want 1", in_ready); end
    exp_q.push_back(b);
    tick();
    in_valid = 1'b0;
    n_checks++; if (svalid !== 1'b1) begin n_fail++; $display("FAIL bb_svalid: got %b want 1", svalid); end
    n_checks++; if (sdata !== 32'hBBBB_0002) begin n_fail++; $display("FAIL bb_sdata: got %h want bbbb0002", sdata); end
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bb_ov: got %b want 1", out_valid); end
    tick();
  endtask

  task automatic test_reset_mid_wait;
    logic [DW-1:0] d;
    smatch = 1'b1;
    accept(mk(32'hDEAD_0003));
    tick();
    smatch = 1'b0;
    tick();
    n_checks++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL rw_stall: got %b want 1", hazard_stall); end
    rstn = 1'b0;
    #1;
    exp_q.delete();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rw_ir: got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rw_ov: got %b want 0", out_valid); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL rw_od: got %h want 0", out_data); end
    n_checks++; if (svalid !== 1'b0) begin n_fail++; $display("FAIL rw_sv: got %b want 0", svalid); end
    n_checks++; if (sdata !== '0) begin n_fail++; $display("FAIL rw_sd: got %h want 0", sdata); end
    n_checks++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL rw_hs: got %b want 0", hazard_stall); end
    n_checks++; if (hazard_timeout !== 1'b0) begin n_fail++; $display("FAIL rw_to: got %b want 0", hazard_timeout); end
    tick();
    rstn = 1'b1;
    tick();
    d = mk(32'h0000_BEEF);
    accept(d);
    n_checks++; if (svalid !== 1'b1) begin n_fail++; $display("FAIL rw_svalid2: got %b want 1", svalid); end
    n_checks++; if (sdata !== 32'h0000_BEEF) begin n_fail++; $display("FAIL rw_sdata2: got %h want beef", sdata); end
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rw_ov2: got %b want 1", out_valid); end
    tick();
  endtask

`ifdef AH_SNOOP_HAZARD_CNT_EN
  task automatic test_hazard_count;
    bit done;
    n_checks++; if (hazard_count !== 16'd0) begin n_fail++; $display("FAIL hc_start: got %0d want 0", hazard_count); end
    smatch = 1'b1;
    accept(mk(32'h0C0C_0005));
    for (int k = 2; k <= 22; k++) begin
      tick();
      if (k == 22) smatch = 1'b0;
    end
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      tick();
      done = out_valid;
    end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL hc_release: got out_valid %b want 1", out_valid); end
    tick();
    n_checks++; if (hazard_count !== 16'd5) begin n_fail++; $display("FAIL hc_count: got %0d want 5", hazard_count); end
    rstn = 1'b0;
    #1;
    n_checks++; if (hazard_count !== 16'd0) begin n_fail++; $display("FAIL hc_reset: got %0d want 0", hazard_count); end
    tick();
    rstn = 1'b1;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_no_hazard();
    test_single_hazard();
    test_timeout();
    test_back_to_back();
    test_reset_mid_wait();
`ifdef AH_SNOOP_HAZARD_CNT_EN
    test_hazard_count();
`endif
    tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
